// File: rtl/conv_out_wb_if.sv
// Bus bundle for the convolution writeback stage: job control, accumulator
// stream in, vector-memory write port out, and status.
interface conv_out_wb_if #(
  parameter int CORE_N   = 4,
  parameter int INTWIDTH = 16,
  parameter int ACCW     = 32,
  parameter int VAW      = 16
);
  logic                       start;
  logic [15:0]                row;
  logic [15:0]                col;
  logic [VAW-1:0]             dY_addr_rds;
  logic [4:0]                 shift;
  logic                       cout_valid;
  logic                       cout_ready;
  logic [CORE_N*ACCW-1:0]     cout_data;
  logic [CORE_N*INTWIDTH-1:0] aw;
  logic                       wr_en;
  logic                       wr_ready;
  logic [VAW-1:0]             wr_addr;
  logic [CORE_N*INTWIDTH-1:0] wr_data;
  logic                       busy;
  logic                       done;

  modport master (
    output start, row, col, dY_addr_rds, shift, cout_valid, cout_data, aw, wr_ready,
    input  cout_ready, wr_en, wr_addr, wr_data, busy, done
  );

  modport slave (
    input  start, row, col, dY_addr_rds, shift, cout_valid, cout_data, aw, wr_ready,
    output cout_ready, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/conv_out_wb.sv
// Conv writeback: bias add, rounding right shift, saturation, packed memory writes.
// Optional ReLU clamp of negative results when CONV_WB_RELU_EN is defined.
module conv_out_wb #(
  parameter int CORE_N   = 4,
  parameter int INTWIDTH = 16,
  parameter int ACCW     = 32,
  parameter int VAW      = 16
) (
  input logic          clk,
  input logic          rst,
  conv_out_wb_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic                       r_busy;
  logic                       r_done;
  logic [31:0]                r_total;
  logic [VAW-1:0]             r_base;
  logic [4:0]                 r_shift;
  logic [31:0]                r_accepted;
  logic [31:0]                r_written;
  logic                       r_s1_valid;
  logic signed [ACCW:0]       r_s1_sum [CORE_N];
  logic                       r_s2_valid;
  logic [CORE_N*INTWIDTH-1:0] r_s2_data;

  logic [31:0]                w_total_in;
  logic                       w_s2_adv;
  logic                       w_s1_adv;
  logic                       w_accept;
  logic                       w_wr_fire;
  logic [CORE_N*INTWIDTH-1:0] w_q;

  // Rounding shift then clamp to the signed output range; the extra top bit keeps the rounding add from overflowing.
  function automatic logic [INTWIDTH-1:0] quant(input logic signed [ACCW:0] s, input logic [4:0] sh);
    logic signed [ACCW+1:0] t;
    logic signed [ACCW+1:0] rnd;
    logic signed [ACCW+1:0] maxv;
    logic signed [ACCW+1:0] minv;
    maxv = '0;
    maxv[INTWIDTH-2:0] = '1;
    minv = '1;
    minv[INTWIDTH-2:0] = '0;
    rnd = '0;
    if (sh != 5'd0) rnd[sh - 5'd1] = 1'b1;
    t = {s[ACCW], s};
    t = t + rnd;
    t = t >>> sh;
    if (t > maxv) t = maxv;
    else if (t < minv) t = minv;
`ifdef CONV_WB_RELU_EN
    if (t[ACCW+1]) t = '0;
`else
`endif
    return t[INTWIDTH-1:0];
  endfunction

  assign w_total_in = {16'b0, bus.row} * {16'b0, bus.col};
  assign w_s2_adv   = !r_s2_valid || bus.wr_ready;
  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign w_wr_fire  = r_s2_valid && bus.wr_ready;

  assign bus.cout_ready = (r_state == S_RUN) && (r_accepted < r_total) && w_s1_adv;
  assign w_accept       = bus.cout_valid && bus.cout_ready;

  assign bus.wr_en   = r_s2_valid;
  assign bus.wr_data = r_s2_data;
  assign bus.wr_addr = r_base + r_written[VAW-1:0];
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

  always_comb begin
    w_q = '0;
    for (int i = 0; i < CORE_N; i++) begin
      w_q[i*INTWIDTH +: INTWIDTH] = quant(r_s1_sum[i], r_shift);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = (w_total_in == 32'd0) ? S_DONE : S_RUN;
      S_RUN:   if (r_accepted == r_total) w_next = S_FLUSH;
      S_FLUSH: if (r_written == r_total) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // busy/done are registered so a zero-size job still shows one busy cycle before done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_total    <= '0;
      r_base     <= '0;
      r_shift    <= '0;
      r_accepted <= '0;
      r_written  <= '0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      for (int i = 0; i < CORE_N; i++) r_s1_sum[i] <= '0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_done <= (r_state == S_DONE);
      if (r_state == S_IDLE && bus.start) begin
        r_total    <= w_total_in;
        r_base     <= bus.dY_addr_rds;
        r_shift    <= bus.shift;
        r_accepted <= '0;
        r_written  <= '0;
      end else begin
        if (w_accept)  r_accepted <= r_accepted + 32'd1;
        if (w_wr_fire) r_written  <= r_written + 32'd1;
      end
      if (w_s1_adv) begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          for (int i = 0; i < CORE_N; i++) begin
            r_s1_sum[i] <= $signed({bus.cout_data[i*ACCW+ACCW-1], bus.cout_data[i*ACCW +: ACCW]})
                         + $signed({{(ACCW+1-INTWIDTH){bus.aw[i*INTWIDTH+INTWIDTH-1]}},
                                    bus.aw[i*INTWIDTH +: INTWIDTH]});
          end
        end
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) r_s2_data <= w_q;
      end
    end
  end

endmodule

// File: tb/tb_conv_out_wb.sv
// Randomised bench for conv_out_wb against a queue-based behavioural model.
module tb_conv_out_wb;
  localparam int CN = 4;
  localparam int IW = 16;
  localparam int AW = 32;
  localparam int VW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_out_wb_if #(.CORE_N(CN), .INTWIDTH(IW), .ACCW(AW), .VAW(VW)) bus ();
  conv_out_wb #(.CORE_N(CN), .INTWIDTH(IW), .ACCW(AW), .VAW(VW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [15:0] addr;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int readyMode = 0;
  exp_t expQ[$];
  logic [63:0] dataLog[$];
  logic [15:0] addrLog[$];
  bit modelActive = 0;
  longint modelTotal = 0;
  longint modelAccepted = 0;
  longint modelWritten = 0;
  longint inflight;
  logic [15:0] modelBase = '0;
  int modelShift = 0;
  int modelStartCycle = 0;
  int doneCount = 0;
  int doneCycle = 0;
  bit checkLatency = 0;
  bit frontSeen = 0;
  exp_t e;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic failNow(input string name, input string detail);
    total++;
    bad++;
    $display("[TB] FAIL %s: %s (cycle %0d)", name, detail, cycle);
  endtask

  function automatic logic [15:0] modelLane(input longint c, input longint a, input int sh);
    longint v;
    v = c + a;
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
    v = v >>> sh;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`ifdef CONV_WB_RELU_EN
    if (v < 0) v = 0;
`endif
    return 16'(v);
  endfunction

  function automatic logic [63:0] modelBeat(input logic [127:0] d, input logic [63:0] a, input int sh);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < CN; i++) begin
      r[i*16 +: 16] = modelLane(longint'($signed(d[i*32 +: 32])), longint'($signed(a[i*16 +: 16])), sh);
    end
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  initial begin
    bus.wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0: bus.wr_ready = 1'b1;
        1: bus.wr_ready = ((cycle % 4) == 0) || ((cycle % 4) == 3);
        default: bus.wr_ready = 1'($urandom % 2);
      endcase
    end
  end

  // Model: every accepted beat queues its expected write; every write must match the queue head.
  always @(negedge clk) begin
    inflight = modelAccepted - modelWritten;
    if (bus.wr_en) begin
      checkOutput("busyDuringWrite", 64'(bus.busy), 64'd1);
      if (expQ.size() == 0) begin
        failNow("unexpectedWrite", $sformatf("got write addr %0h expected no write", bus.wr_addr));
      end else begin
        checkOutput("wrAddr", 64'(bus.wr_addr), 64'(expQ[0].addr));
        checkOutput("wrData", bus.wr_data, expQ[0].data);
        if (checkLatency && !frontSeen) checkOutput("latency", 64'(cycle - expQ[0].cyc), 64'd2);
        frontSeen = 1;
        if (bus.wr_ready) begin
          addrLog.push_back(bus.wr_addr);
          dataLog.push_back(bus.wr_data);
          void'(expQ.pop_front());
          frontSeen = 0;
          modelWritten++;
        end
      end
      if (!bus.wr_ready && inflight >= 2) checkOutput("readyWhenFull", 64'(bus.cout_ready), 64'd0);
    end
    if (bus.cout_ready && (!modelActive || modelAccepted >= modelTotal)) begin
      failNow("readyOutsideJob", "got cout_ready 1 expected 0");
    end else if (bus.cout_valid && bus.cout_ready) begin
      e.addr = modelBase + 16'(modelAccepted);
      e.data = modelBeat(bus.cout_data, bus.aw, modelShift);
      e.cyc  = cycle;
      expQ.push_back(e);
      modelAccepted++;
    end
    if (bus.done) begin
      doneCount++;
      doneCycle = cycle;
      checkOutput("doneWhileActive", 64'(modelActive), 64'd1);
      checkOutput("busyAtDone", 64'(bus.busy), 64'd0);
      checkOutput("writesAtDone", 64'(modelWritten), 64'(modelTotal));
      modelActive = 0;
    end
    if (rst) begin
      expQ.delete();
      modelActive = 0;
      modelAccepted = 0;
      modelWritten = 0;
      frontSeen = 0;
    end else if (bus.start && !modelActive) begin
      modelBase = bus.dY_addr_rds;
      modelShift = int'(bus.shift);
      modelTotal = longint'(bus.row) * longint'(bus.col);
      modelAccepted = 0;
      modelWritten = 0;
      modelActive = 1;
      modelStartCycle = cycle;
    end
  end

  task automatic pulseStart(input logic [15:0] r, input logic [15:0] c, input logic [15:0] b, input logic [4:0] s);
    bus.row = r;
    bus.col = c;
    bus.dY_addr_rds = b;
    bus.shift = s;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic startJob(input logic [15:0] r, input logic [15:0] c, input logic [15:0] b, input logic [4:0] s);
    doneCount = 0;
    addrLog.delete();
    dataLog.delete();
    pulseStart(r, c, b, s);
  endtask

  task automatic applyStimulus(input logic [127:0] d, input logic [63:0] a);
    int waited;
    bus.cout_data = d;
    bus.aw = a;
    bus.cout_valid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.cout_ready) break;
      waited++;
      if (waited > 200) begin
        failNow("beatTimeout", "got no cout_ready expected accept within 200 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.cout_valid = 1'b0;
  endtask

  function automatic logic [127:0] randBeat();
    logic [127:0] d;
    logic [31:0] lane;
    for (int i = 0; i < CN; i++) begin
      lane = $urandom;
      if ($urandom % 2 == 1) lane = 32'($signed(lane) >>> $urandom_range(0, 31));
      d[i*32 +: 32] = lane;
    end
    return d;
  endfunction

  task automatic waitDone(input int budget);
    for (int i = 0; i < budget && doneCount == 0; i++) @(negedge clk);
    if (doneCount == 0) failNow("doneTimeout", $sformatf("got no done expected done within %0d cycles", budget));
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_coutReady"}, 64'(bus.cout_ready), 64'd0);
    checkOutput({tag, "_wrEn"}, 64'(bus.wr_en), 64'd0);
    checkOutput({tag, "_wrAddr"}, 64'(bus.wr_addr), 64'd0);
    checkOutput({tag, "_wrData"}, bus.wr_data, 64'd0);
    checkOutput({tag, "_busy"}, 64'(bus.busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(bus.done), 64'd0);
  endtask

  logic [15:0] wrapAddr[4];
  int r;
  int c;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.row = '0;
    bus.col = '0;
    bus.dY_addr_rds = '0;
    bus.shift = '0;
    bus.cout_valid = 1'b0;
    bus.cout_data = '0;
    bus.aw = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] basic job 2x3, shift 0");
    readyMode = 0;
    checkLatency = 1;
    startJob(16'd2, 16'd3, 16'h0100, 5'd0);
    for (int i = 0; i < 6; i++) applyStimulus({96'h0, 32'(10 + i)}, {48'h0, 16'h0001});
    waitDone(100);
    checkLatency = 0;
    repeat (3) @(negedge clk);
    checkOutput("t1DonePulses", 64'(doneCount), 64'd1);
    checkOutput("t1Writes", 64'(addrLog.size()), 64'd6);
    for (int i = 0; i < 6 && i < addrLog.size(); i++) begin
      checkOutput("t1Addr", 64'(addrLog[i]), 64'(16'h0100 + i));
      checkOutput("t1Lane0", 64'(dataLog[i][15:0]), 64'(11 + i));
    end
    @(posedge clk);
    #1;

    $display("[TB] rounding and saturation, shift 4");
    startJob(16'd1, 16'd2, 16'h0200, 5'd4);
    applyStimulus({32'h0, 32'h8000_0000, 32'h7FFF_FFFF, 32'd40}, 64'h0);
    applyStimulus({96'h0, 32'hFFFF_FFD8}, 64'h0);
    waitDone(100);
    if (dataLog.size() == 2) begin
      checkOutput("t2Pos", 64'(dataLog[0][15:0]), 64'h0003);
      checkOutput("t2SatHi", 64'(dataLog[0][31:16]), 64'h7FFF);
`ifdef CONV_WB_RELU_EN
      checkOutput("t2SatLo", 64'(dataLog[0][47:32]), 64'h0000);
      checkOutput("t2Neg", 64'(dataLog[1][15:0]), 64'h0000);
`else
      checkOutput("t2SatLo", 64'(dataLog[0][47:32]), 64'h8000);
      checkOutput("t2Neg", 64'(dataLog[1][15:0]), 64'hFFFE);
`endif
    end else begin
      failNow("t2Writes", $sformatf("got %0d writes expected 2", dataLog.size()));
    end

    $display("[TB] backpressure 1,0,0,1");
    readyMode = 1;
    startJob(16'd1, 16'd8, 16'h0300, 5'd1);
    for (int i = 0; i < 8; i++) applyStimulus(randBeat(), {$urandom, $urandom});
    waitDone(300);
    checkOutput("t3Writes", 64'(addrLog.size()), 64'd8);
    for (int i = 0; i < addrLog.size(); i++) checkOutput("t3Addr", 64'(addrLog[i]), 64'(16'h0300 + i));

    $display("[TB] empty job");
    readyMode = 0;
    startJob(16'd0, 16'd28, 16'h0400, 5'd0);
    @(negedge clk);
    checkOutput("t4Busy", 64'(bus.busy), 64'd1);
    waitDone(20);
    checkOutput("t4DoneDelay", 64'(doneCycle - modelStartCycle), 64'd2);
    checkOutput("t4Writes", 64'(addrLog.size()), 64'd0);

    $display("[TB] address wrap and ignored restart");
    readyMode = 2;
    startJob(16'd1, 16'd4, 16'hFFFE, 5'd3);
    applyStimulus(randBeat(), {$urandom, $urandom});
    applyStimulus(randBeat(), {$urandom, $urandom});
    pulseStart(16'd5, 16'd5, 16'h0000, 5'd0);
    applyStimulus(randBeat(), {$urandom, $urandom});
    applyStimulus(randBeat(), {$urandom, $urandom});
    waitDone(300);
    repeat (3) @(negedge clk);
    checkOutput("t5DonePulses", 64'(doneCount), 64'd1);
    wrapAddr[0] = 16'hFFFE;
    wrapAddr[1] = 16'hFFFF;
    wrapAddr[2] = 16'h0000;
    wrapAddr[3] = 16'h0001;
    checkOutput("t5Writes", 64'(addrLog.size()), 64'd4);
    for (int i = 0; i < 4 && i < addrLog.size(); i++) checkOutput("t5Addr", 64'(addrLog[i]), 64'(wrapAddr[i]));
    @(posedge clk);
    #1;

    $display("[TB] reset mid-job");
    readyMode = 0;
    startJob(16'd1, 16'd8, 16'h0500, 5'd2);
    for (int i = 0; i < 3; i++) applyStimulus(randBeat(), {$urandom, $urandom});
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkResetOutputs("midReset");
    repeat (10) @(negedge clk);
    checkOutput("t6WritesBeforeReset", 64'(addrLog.size()), 64'd2);
    @(posedge clk);
    #1;
    startJob(16'd1, 16'd3, 16'h0600, 5'd0);
    for (int i = 0; i < 3; i++) applyStimulus(randBeat(), {$urandom, $urandom});
    waitDone(100);
    checkOutput("t6WritesAfter", 64'(addrLog.size()), 64'd3);

    $display("[TB] random jobs");
    readyMode = 2;
    for (int j = 0; j < 4; j++) begin
      r = $urandom_range(1, 3);
      c = $urandom_range(1, 4);
      startJob(16'(r), 16'(c), 16'($urandom), 5'($urandom_range(0, 31)));
      for (int i = 0; i < r * c; i++) begin
        repeat ($urandom % 3) begin
          @(posedge clk);
          #1;
        end
        applyStimulus(randBeat(), {$urandom, $urandom});
      end
      waitDone(500);
      checkOutput("randWrites", 64'(addrLog.size()), 64'(r * c));
    end

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
